ecc_decode_monitor: RTL and testbench

// Sits directly downstream of the 13-bit SEC-DED Hamming decoder and consumes its
// per-word results (data_out, syndrome, error_type). It buffers corrected bytes in
// a small FIFO toward the consumer over a valid/ready interface, and tags uncorrectable

---
 rtl/ecc_decode_monitor.sv | 128 ++++++++++++
 tb/tb_ecc_decode_monitor.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_decode_monitor.sv
// Post-decoder monitor for a 13-bit SEC-DED Hamming decoder: buffers corrected bytes
// in a small FIFO and keeps saturating error-class counters with a sticky multi-bit alarm.
module ecc_decode_monitor #(
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16,
    parameter int THRESH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [3:0]       in_syndrome,
    input  logic [1:0]       in_err_type,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_uncorr,
    input  logic             clr_counters,
    output logic [CNT_W-1:0] cnt_wp,
    output logic [CNT_W-1:0] cnt_single,
    output logic [CNT_W-1:0] cnt_multi,
    output logic [3:0]       last_bad_syn,
    output logic             alarm
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    typedef enum logic {
        MONITOR = 1'b0,
        ALARM   = 1'b1
    } state_t;

    state_t           state;
    logic [8:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [8:0]       head;
    logic             accept;
    logic             pop;
    logic [CNT_W-1:0] wp_nxt;
    logic [CNT_W-1:0] single_nxt;
    logic [CNT_W-1:0] multi_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Full blocks new words even when the head pops this cycle; there is no bypass path.
    assign in_ready   = (count != FULL_CNT);
    assign out_valid  = (count != '0);
    assign accept     = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign head       = mem[rd_ptr];
    assign out_data   = out_valid ? head[7:0] : 8'h00;
    assign out_uncorr = out_valid ? head[8] : 1'b0;
    assign alarm      = (state == ALARM);

    // NOTE: storage has no reset; validity is tracked by count, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {(in_err_type == 2'b11), in_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        wp_nxt     = cnt_wp;
        single_nxt = cnt_single;
        multi_nxt  = cnt_multi;
        if (accept) begin
            case (in_err_type)
                2'b01:   wp_nxt     = sat_inc(cnt_wp);
                2'b10:   single_nxt = sat_inc(cnt_single);
                2'b11:   multi_nxt  = sat_inc(cnt_multi);
                default: ;
            endcase
        end
    end

    // Clear wins over a same-cycle accept for statistics only; the FIFO still takes the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_wp       <= '0;
            cnt_single   <= '0;
            cnt_multi    <= '0;
            last_bad_syn <= 4'h0;
            state        <= MONITOR;
        end else if (clr_counters) begin
            cnt_wp       <= '0;
            cnt_single   <= '0;
            cnt_multi    <= '0;
            last_bad_syn <= 4'h0;
            state        <= MONITOR;
        end else begin
            cnt_wp     <= wp_nxt;
            cnt_single <= single_nxt;
            cnt_multi  <= multi_nxt;
            if (accept && in_err_type == 2'b11) last_bad_syn <= in_syndrome;
            case (state)
                MONITOR: if (multi_nxt >= THRESH_C) state <= ALARM;
                ALARM:   state <= ALARM;
                default: state <= MONITOR;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_decode_monitor.sv
// Directed bench for ecc_decode_monitor, built with DEPTH=4, CNT_W=2, THRESH=2 so that
// saturation and the alarm threshold are reachable in a few words.
module tb_ecc_decode_monitor;

    localparam int DEPTH  = 4;
    localparam int CNT_W  = 2;
    localparam int THRESH = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic [3:0]       in_syndrome;
    logic [1:0]       in_err_type;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_uncorr;
    logic             clr_counters;
    logic [CNT_W-1:0] cnt_wp;
    logic [CNT_W-1:0] cnt_single;
    logic [CNT_W-1:0] cnt_multi;
    logic [3:0]       last_bad_syn;
    logic             alarm;

    int checks;
    int errors;

    ecc_decode_monitor #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .THRESH(THRESH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_syndrome (in_syndrome),
        .in_err_type (in_err_type),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_uncorr  (out_uncorr),
        .clr_counters(clr_counters),
        .cnt_wp      (cnt_wp),
        .cnt_single  (cnt_single),
        .cnt_multi   (cnt_multi),
        .last_bad_syn(last_bad_syn),
        .alarm       (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed status: {cnt_wp, cnt_single, cnt_multi, last_bad_syn, alarm}.
    function automatic logic [10:0] stats();
        return {cnt_wp, cnt_single, cnt_multi, last_bad_syn, alarm};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({in_ready, out_valid, out_data, out_uncorr} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_fifo: got rdy/vld/data/unc=%b/%b/%h/%b want 1/0/00/0",
                     in_ready, out_valid, out_data, out_uncorr);
        end
        checks++;
        if (stats() !== 11'h000) begin
            errors++;
            $display("FAIL reset_stats: got %h want 000", stats());
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp [4];
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        out_ready   = 1'b0;
        in_err_type = 2'b00;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = exp[i];
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_ready[%0d]: got %b want 1", i, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, 8'h11}) begin
            errors++;
            $display("FAIL full_state: got rdy/vld/data=%b/%b/%h want 0/1/11",
                     in_ready, out_valid, out_data);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_valid, out_data, out_uncorr} !== {1'b1, exp[i], 1'b0}) begin
                errors++;
                $display("FAIL drain[%0d]: got vld/data/unc=%b/%h/%b want 1/%h/0",
                         i, out_valid, out_data, out_uncorr, exp[i]);
            end
            tick();
        end
        checks++;
        if ({in_ready, out_valid, out_data} !== {1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL drained_empty: got rdy/vld/data=%b/%b/%h want 1/0/00",
                     in_ready, out_valid, out_data);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stream();
        logic [7:0] model [$];
        logic [7:0] nxt;
        nxt         = 8'hA0;
        in_err_type = 2'b00;
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            in_data = nxt;
            tick();
            model.push_back(nxt);
            nxt++;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = nxt;
            checks++;
            if ({in_ready, out_valid, out_data} !== {1'b1, 1'b1, model[0]}) begin
                errors++;
                $display("FAIL stream[%0d]: got rdy/vld/data=%b/%b/%h want 1/1/%h",
                         i, in_ready, out_valid, out_data, model[0]);
            end
            tick();
            void'(model.pop_front());
            model.push_back(nxt);
            nxt++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            checks++;
            if ({out_valid, out_data} !== {1'b1, model[0]}) begin
                errors++;
                $display("FAIL stream_tail[%0d]: got vld/data=%b/%h want 1/%h",
                         i, out_valid, out_data, model[0]);
            end
            tick();
            void'(model.pop_front());
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_empty: got out_valid=%b want 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_counters();
        logic [1:0] types [4];
        types       = '{2'b01, 2'b10, 2'b10, 2'b11};
        out_ready   = 1'b0;
        in_syndrome = 4'hA;
        in_valid    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_err_type = types[i];
            in_data     = 8'h51 + 8'(i);
            tick();
        end
        in_valid    = 1'b0;
        in_err_type = 2'b00;
        in_syndrome = 4'h0;
        checks++;
        // wp=1, single=2, multi=1, syn=A, alarm=0
        if (stats() !== {2'd1, 2'd2, 2'd1, 4'hA, 1'b0}) begin
            errors++;
            $display("FAIL class_counts: got %h want %h", stats(), {2'd1, 2'd2, 2'd1, 4'hA, 1'b0});
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_data, out_uncorr} !== {8'h51 + 8'(i), (i == 3)}) begin
                errors++;
                $display("FAIL uncorr_tag[%0d]: got data/unc=%h/%b want %h/%b",
                         i, out_data, out_uncorr, 8'h51 + 8'(i), (i == 3));
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_alarm();
        clr_counters = 1'b1;
        tick();
        clr_counters = 1'b0;
        checks++;
        if (stats() !== 11'h000) begin
            errors++;
            $display("FAIL pre_alarm_clear: got %h want 000", stats());
        end
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_err_type = 2'b11;
        in_syndrome = 4'h3;
        in_data     = 8'h61;
        tick();
        checks++;
        if ({cnt_multi, last_bad_syn, alarm} !== {2'd1, 4'h3, 1'b0}) begin
            errors++;
            $display("FAIL multi_first: got cnt/syn/alarm=%0d/%h/%b want 1/3/0",
                     cnt_multi, last_bad_syn, alarm);
        end
        in_syndrome = 4'h5;
        in_data     = 8'h62;
        tick();
        checks++;
        if ({cnt_multi, last_bad_syn, alarm} !== {2'd2, 4'h5, 1'b1}) begin
            errors++;
            $display("FAIL alarm_set: got cnt/syn/alarm=%0d/%h/%b want 2/5/1",
                     cnt_multi, last_bad_syn, alarm);
        end
        in_err_type = 2'b00;
        in_syndrome = 4'h0;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'h70 + 8'(i);
            tick();
            checks++;
            if ({cnt_multi, alarm} !== {2'd2, 1'b1}) begin
                errors++;
                $display("FAIL alarm_sticky[%0d]: got cnt/alarm=%0d/%b want 2/1", i, cnt_multi, alarm);
            end
        end
        in_valid     = 1'b0;
        clr_counters = 1'b1;
        tick();
        clr_counters = 1'b0;
        checks++;
        if (stats() !== 11'h000) begin
            errors++;
            $display("FAIL alarm_clear: got %h want 000", stats());
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL alarm_drain: got out_valid=%b want 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_clr_accept();
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_err_type = 2'b10;
        in_data     = 8'h76;
        tick();
        in_valid = 1'b0;
        checks++;
        if (cnt_single !== 2'd1) begin
            errors++;
            $display("FAIL pre_clr_single: got %0d want 1", cnt_single);
        end
        tick();
        in_valid     = 1'b1;
        in_data      = 8'h77;
        clr_counters = 1'b1;
        tick();
        in_valid     = 1'b0;
        clr_counters = 1'b0;
        checks++;
        if ({cnt_single, out_valid, out_data, out_uncorr} !== {2'd0, 1'b1, 8'h77, 1'b0}) begin
            errors++;
            $display("FAIL clr_vs_accept: got single/vld/data/unc=%0d/%b/%h/%b want 0/1/77/0",
                     cnt_single, out_valid, out_data, out_uncorr);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_saturate_reset();
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_err_type = 2'b10;
        for (int i = 1; i <= 5; i++) begin
            in_data = 8'h80 + 8'(i);
            tick();
            checks++;
            if (cnt_single !== ((i > 3) ? 2'd3 : 2'(i))) begin
                errors++;
                $display("FAIL saturate[%0d]: got %0d want %0d", i, cnt_single, (i > 3) ? 3 : i);
            end
        end
        checks++;
        if ({out_valid, out_data} !== {1'b1, 8'h85}) begin
            errors++;
            $display("FAIL pre_reset_head: got vld/data=%b/%h want 1/85", out_valid, out_data);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_data, out_uncorr, stats()} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 11'h000}) begin
            errors++;
            $display("FAIL mid_reset: got rdy/vld/data/unc/stats=%b/%b/%h/%b/%h want 1/0/00/0/000",
                     in_ready, out_valid, out_data, out_uncorr, stats());
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({in_ready, out_valid, stats()} !== {1'b1, 1'b0, 11'h000}) begin
            errors++;
            $display("FAIL post_reset: got rdy/vld/stats=%b/%b/%h want 1/0/000",
                     in_ready, out_valid, stats());
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b1;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        in_syndrome  = 4'h0;
        in_err_type  = 2'b00;
        out_ready    = 1'b0;
        clr_counters = 1'b0;
        #2;
        test_reset();
        test_fill_drain();
        test_stream();
        test_counters();
        test_alarm();
        test_clr_accept();
        test_saturate_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
